// File: rtl/ide_pio_sequencer_if.sv
// Bus bundle between the 68020/Gayle decode side and the IDE PIO sequencer.
// The master drives the CPU strobes and IORDY; the slave (sequencer) drives the ATA and ack lines.
interface ide_pio_sequencer_if;
  logic       AS20;
  logic       DS20;
  logic       RW20;
  logic       IDE_SEL;
  logic       A12;
  logic       IORDY;
  logic [1:0] IDECS;
  logic       IOR;
  logic       IOW;
  logic [1:0] DSACK;
  logic       DLATCH;
  logic       TIMEOUT;

  modport master (
    output AS20, DS20, RW20, IDE_SEL, A12, IORDY,
    input  IDECS, IOR, IOW, DSACK, DLATCH, TIMEOUT
  );

  modport slave (
    input  AS20, DS20, RW20, IDE_SEL, A12, IORDY,
    output IDECS, IOR, IOW, DSACK, DLATCH, TIMEOUT
  );
endinterface

// File: rtl/ide_pio_sequencer.sv
// Turns decoded 68020 IDE accesses into timed ATA PIO strobes with IORDY wait states,
// a 16-bit DSACK acknowledge and a read-data latch pulse. All outputs are registered.
module ide_pio_sequencer #(
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_ACTIVE  = 6,
  parameter int unsigned T_HOLD    = 1,
  parameter int unsigned T_RECOVER = 4,
  parameter int unsigned T_TIMEOUT = 255
) (
  input logic                 CLKCPU,
  input logic                 RESET,
  ide_pio_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP, ACTIVE, ACK, HOLD, RECOVER
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] phase, phase_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       rw_lat, rw_nxt;
  logic       a12_lat, a12_nxt;
  logic [1:0] idecs_r, idecs_nxt;
  logic       ior_r, ior_nxt;
  logic       iow_r, iow_nxt;
  logic [1:0] dsack_r, dsack_nxt;
  logic       dlatch_r, dlatch_nxt;
  logic       timeout_r, timeout_nxt;

  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      state     <= IDLE;
      phase     <= '0;
      wait_cnt  <= '0;
      rw_lat    <= 1'b1;
      a12_lat   <= 1'b0;
      idecs_r   <= 2'b11;
      ior_r     <= 1'b1;
      iow_r     <= 1'b1;
      dsack_r   <= 2'b11;
      dlatch_r  <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      wait_cnt  <= wait_nxt;
      rw_lat    <= rw_nxt;
      a12_lat   <= a12_nxt;
      idecs_r   <= idecs_nxt;
      ior_r     <= ior_nxt;
      iow_r     <= iow_nxt;
      dsack_r   <= dsack_nxt;
      dlatch_r  <= dlatch_nxt;
      timeout_r <= timeout_nxt;
    end
  end

  // Phase counter acts on the edge where it reads 1, so each phase lasts exactly its T_* cycles.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    wait_nxt    = wait_cnt;
    rw_nxt      = rw_lat;
    a12_nxt     = a12_lat;
    idecs_nxt   = idecs_r;
    ior_nxt     = ior_r;
    iow_nxt     = iow_r;
    dsack_nxt   = dsack_r;
    dlatch_nxt  = 1'b0;
    timeout_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (!bus.AS20 && !bus.DS20 && !bus.IDE_SEL) begin
          rw_nxt    = bus.RW20;
          a12_nxt   = bus.A12;
          idecs_nxt = bus.A12 ? 2'b01 : 2'b10;
          phase_nxt = 4'(T_SETUP);
          state_nxt = SETUP;
        end
      end

      SETUP: begin
        if (bus.AS20) begin
          phase_nxt = 4'(T_HOLD);
          state_nxt = HOLD;
        end else if (phase <= 4'd1) begin
          ior_nxt   = !rw_lat;
          iow_nxt   = rw_lat;
          phase_nxt = 4'(T_ACTIVE);
          wait_nxt  = '0;
          state_nxt = ACTIVE;
        end else begin
          phase_nxt = phase - 4'd1;
        end
      end

      // Once the active time has expired, IORDY low stretches the strobe until the timeout forces ack.
      ACTIVE: begin
        if (bus.AS20) begin
          ior_nxt   = 1'b1;
          iow_nxt   = 1'b1;
          phase_nxt = 4'(T_HOLD);
          state_nxt = HOLD;
        end else if (phase > 4'd1) begin
          phase_nxt = phase - 4'd1;
        end else if (bus.IORDY || (wait_cnt == 8'(T_TIMEOUT))) begin
          dsack_nxt   = 2'b01;
          dlatch_nxt  = rw_lat;
          timeout_nxt = !bus.IORDY;
          phase_nxt   = '0;
          state_nxt   = ACK;
        end else begin
          wait_nxt  = wait_cnt + 8'd1;
          phase_nxt = '0;
        end
      end

      ACK: begin
        if (bus.AS20) begin
          ior_nxt   = 1'b1;
          iow_nxt   = 1'b1;
          dsack_nxt = 2'b11;
          phase_nxt = 4'(T_HOLD);
          state_nxt = HOLD;
        end
      end

      HOLD: begin
        if (phase <= 4'd1) begin
          idecs_nxt = 2'b11;
          phase_nxt = 4'(T_RECOVER);
          state_nxt = RECOVER;
        end else begin
          phase_nxt = phase - 4'd1;
        end
      end

      RECOVER: begin
        if (phase <= 4'd1) begin
          phase_nxt = '0;
          state_nxt = IDLE;
        end else begin
          phase_nxt = phase - 4'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.IDECS   = idecs_r;
  assign bus.IOR     = ior_r;
  assign bus.IOW     = iow_r;
  assign bus.DSACK   = dsack_r;
  assign bus.DLATCH  = dlatch_r;
  assign bus.TIMEOUT = timeout_r;

endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Bench for ide_pio_sequencer: each PIO cycle is predicted from its event edges
// (start, strobe, ack, release, IDECS negation) and every output is compared every cycle.
module tb_ide_pio_sequencer;

  localparam int T_SETUP   = 2;
  localparam int T_ACTIVE  = 6;
  localparam int T_HOLD    = 1;
  localparam int T_RECOVER = 4;
  localparam int T_TIMEOUT = 255;
  localparam logic [7:0] IDLE_OUT = 8'b11_1_1_11_0_0;

  logic CLKCPU;
  logic RESET;
  int   checks;
  int   failures;
  int   cur_k;

  ide_pio_sequencer_if bus ();

  ide_pio_sequencer #(
    .T_SETUP   (T_SETUP),
    .T_ACTIVE  (T_ACTIVE),
    .T_HOLD    (T_HOLD),
    .T_RECOVER (T_RECOVER),
    .T_TIMEOUT (T_TIMEOUT)
  ) dut (
    .CLKCPU (CLKCPU),
    .RESET  (RESET),
    .bus    (bus)
  );

  initial CLKCPU = 1'b0;
  always #5 CLKCPU = ~CLKCPU;

  task automatic applyStimulus(input logic rst, input logic as, input logic ds, input logic sel,
                               input logic rw, input logic a12, input logic iordy);
    RESET       = rst;
    bus.AS20    = as;
    bus.DS20    = ds;
    bus.IDE_SEL = sel;
    bus.RW20    = rw;
    bus.A12     = a12;
    bus.IORDY   = iordy;
  endtask

  task automatic tick();
    @(posedge CLKCPU);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expected);
    logic [7:0] observed;
    observed = {bus.IDECS, bus.IOR, bus.IOW, bus.DSACK, bus.DLATCH, bus.TIMEOUT};
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s k=%0d observed={cs,ior,iow,dsack,dl,to}=%b expected=%b",
             tag, cur_k, observed, expected);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Bus is quiet: either AS20 high or the region decode not selected; nothing may start.
  task automatic idle_cycles(input string tag, input int n);
    logic as;
    for (int i = 0; i < n; i++) begin
      as = rnd();
      applyStimulus(1'b0, as, rnd(), as ? rnd() : 1'b1, rnd(), rnd(), rnd());
      tick();
      cur_k = i;
      checkOutput(tag, IDLE_OUT);
    end
  endtask

  // One PIO cycle starting at edge k=0. abort_k<0 means no abort, rst_k<0 means no reset.
  // With chain set, the next request is already on the bus from the edge after release.
  task automatic run_txn(input string tag, input logic rw, input logic a12, input int iordy_low,
                         input int abort_k, input int rel_gap, input logic chain,
                         input logic nrw, input logic na12, input int rst_k);
    int s, a, lo, ack_k, rel_k, end_k;
    logic timed_out, aborted, strobe, as, sel_in, rw_in, a12_in, iordy_in;
    logic [1:0] sel, idecs, dsack;
    logic [7:0] expected;

    s         = T_SETUP;
    a         = T_ACTIVE;
    timed_out = iordy_low > T_TIMEOUT;
    lo        = timed_out ? T_TIMEOUT + 1 : iordy_low;
    ack_k     = s + a + (timed_out ? T_TIMEOUT : iordy_low);
    aborted   = (abort_k >= 1) && (abort_k <= ack_k);
    rel_k     = aborted ? abort_k : ack_k + 1 + rel_gap;
    end_k     = rel_k + T_HOLD + T_RECOVER;
    sel       = a12 ? 2'b01 : 2'b10;

    for (int k = 0; k <= end_k; k++) begin
      if (k < rel_k)       as = 1'b0;
      else if (k == rel_k) as = 1'b1;
      else                 as = !chain;

      if (k == 0) begin
        sel_in = 1'b0; rw_in = rw; a12_in = a12;
      end else if (chain && k > rel_k) begin
        sel_in = 1'b0; rw_in = nrw; a12_in = na12;
      end else begin
        sel_in = rnd(); rw_in = rnd(); a12_in = rnd();
      end

      if (k >= s + a && k < s + a + lo) iordy_in = 1'b0;
      else if (k == s + a + lo)         iordy_in = 1'b1;
      else                              iordy_in = rnd();

      applyStimulus(k == rst_k, as, as, sel_in, rw_in, a12_in, iordy_in);
      tick();
      cur_k = k;

      if (rst_k >= 0 && k >= rst_k) begin
        expected = IDLE_OUT;
      end else begin
        idecs    = (k < rel_k + T_HOLD) ? sel : 2'b11;
        strobe   = (k >= s) && (k < rel_k);
        dsack    = (!aborted && k >= ack_k && k < rel_k) ? 2'b01 : 2'b11;
        expected = {idecs, !(strobe && rw), !(strobe && !rw), dsack,
                    !aborted && k == ack_k && rw, !aborted && k == ack_k && timed_out};
      end
      checkOutput(tag, expected);
      if (k == rst_k) break;
    end
  endtask

  initial begin
    logic crw, ca12, nrw, na12, chain;
    int   lw, ab;

    checks   = 0;
    failures = 0;
    cur_k    = 0;

    // A pending start request must not get through while reset is held.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      cur_k = i;
      checkOutput("reset", IDLE_OUT);
    end
    idle_cycles("idle", 4);

    run_txn("read_dflt", 1'b1, 1'b1, 0, -1, 0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("idle", 2);
    run_txn("write_dflt", 1'b0, 1'b0, 0, -1, 2, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("idle", 2);
    run_txn("iordy_10", 1'b1, 1'b0, 10, -1, 1, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("idle", 2);
    run_txn("iordy_stuck", 1'b1, 1'b1, 400, -1, 0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("idle", 2);
    run_txn("iordy_edge", 1'b0, 1'b1, T_TIMEOUT, -1, 0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("idle", 2);

    run_txn("b2b_first", 1'b1, 1'b1, 0, -1, 0, 1'b1, 1'b0, 1'b0, -1);
    run_txn("b2b_second", 1'b0, 1'b0, 0, -1, 0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("idle", 2);

    run_txn("abort_active", 1'b1, 1'b0, 0, T_SETUP + 3, 0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("idle", 2);
    run_txn("abort_setup", 1'b0, 1'b1, 0, 1, 0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("idle", 2);

    run_txn("reset_active", 1'b1, 1'b1, 0, -1, 0, 1'b0, 1'b0, 1'b0, T_SETUP + 2);
    idle_cycles("post_reset", 2);
    run_txn("after_reset", 1'b1, 1'b0, 0, -1, 0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("idle", 2);

    crw  = rnd();
    ca12 = rnd();
    for (int i = 0; i < 20; i++) begin
      nrw   = rnd();
      na12  = rnd();
      chain = (i < 19) && ($urandom_range(0, 2) == 0);
      lw    = int'($urandom_range(0, 12));
      ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, T_SETUP + T_ACTIVE + lw)) : -1;
      run_txn("random", crw, ca12, lw, ab, int'($urandom_range(0, 3)), chain, nrw, na12, -1);
      if (!chain) idle_cycles("idle", int'($urandom_range(1, 3)));
      crw  = nrw;
      ca12 = na12;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
